// File: rtl/pc_sequencer.sv
// Program-counter sequencer: presents the fetch PC over valid/ready and applies prioritised
// redirects. A redirect that cannot fire yet is held until fetch accepts the current PC.
module pc_sequencer #(
  parameter int unsigned     DW       = 64,
  parameter logic [DW-1:0]   RESET_PC = DW'(64'h8000_0000),
  parameter int unsigned     IALIGN   = 4
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          o_if_valid,
  input  logic          i_if_ready,
  output logic          o_if_kill,
  output logic [DW-1:0] o_pc,
  output logic [DW-1:0] o_snxt_pc,
  output logic [DW-1:0] o_dnxt_pc,
  input  logic [DW-1:0] i_ex_pc,
  input  logic [DW-1:0] i_imm,
  input  logic [DW-1:0] i_result,
  input  logic          i_br_en,
  input  logic          i_jal_en,
  input  logic          i_jalr_en,
  input  logic          i_trap_en,
  input  logic [DW-1:0] i_trap_vec,
  input  logic          i_mret_en,
  input  logic [DW-1:0] i_epc,
  output logic          o_misalign,
  output logic [DW-1:0] o_misalign_addr
);

  localparam logic [DW-1:0] AlignMask = DW'(IALIGN - 1);
  localparam logic [DW-1:0] OddMask   = DW'(1);
  localparam logic [DW-1:0] Step      = DW'(4);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e        r_state;
  logic [DW-1:0] r_pc;
  logic [DW-1:0] r_pend;
  logic          r_valid;
  logic          r_misalign;
  logic [DW-1:0] r_misalign_addr;

  state_e        w_state_nxt;
  logic [DW-1:0] w_pc_nxt;
  logic [DW-1:0] w_pend_nxt;
  logic          w_kill;
  logic          w_fire;
  logic          w_tm_en;
  logic [DW-1:0] w_tm_tgt;
  logic          w_cj_en;
  logic [DW-1:0] w_cj_tgt;
  logic          w_cj_mis;
  logic          w_run_redir;
  logic [DW-1:0] w_run_tgt;
  logic          w_raise_mis;

  assign w_fire = r_valid & i_if_ready;

  // Trap and mret targets are forced aligned; they can never raise a misalign.
  assign w_tm_en  = i_trap_en | i_mret_en;
  assign w_tm_tgt = i_trap_en ? (i_trap_vec & ~AlignMask) : (i_epc & ~AlignMask);

  assign w_cj_en  = i_jalr_en | i_jal_en | i_br_en;
  assign w_cj_tgt = i_jalr_en ? (i_result & ~OddMask) :
                    i_jal_en  ? i_result : (i_ex_pc + i_imm);
  assign w_cj_mis = |(w_cj_tgt & AlignMask);

  assign w_run_redir = w_tm_en | (w_cj_en & ~w_cj_mis);
  assign w_run_tgt   = w_tm_en ? w_tm_tgt : w_cj_tgt;
  assign w_raise_mis = (r_state == StRun) & w_cj_en & w_cj_mis & ~w_tm_en;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_kill      = 1'b0;
    unique case (r_state)
      StBoot: w_state_nxt = StRun;
      StRun: begin
        if (w_run_redir) begin
          if (w_fire) begin
            w_pc_nxt = w_run_tgt;
            w_kill   = 1'b1;
          end else begin
            w_pend_nxt  = w_run_tgt;
            w_state_nxt = StHold;
          end
        end else if (w_fire) begin
          w_pc_nxt = r_pc + Step;
        end
      end
      StHold: begin
        // Execute-stage jumps seen here are wrong-path; only trap/mret may retarget.
        if (w_fire) begin
          w_pc_nxt    = w_tm_en ? w_tm_tgt : r_pend;
          w_kill      = 1'b1;
          w_state_nxt = StRun;
        end else if (w_tm_en) begin
          w_pend_nxt = w_tm_tgt;
        end
      end
      default: w_state_nxt = StBoot;
    endcase
    if (!rstn) begin
      w_pc_nxt = RESET_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state         <= StBoot;
      r_pc            <= RESET_PC;
      r_pend          <= '0;
      r_valid         <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend     <= w_pend_nxt;
      r_valid    <= (w_state_nxt != StBoot);
      r_misalign <= w_raise_mis;
      if (w_raise_mis) begin
        r_misalign_addr <= w_cj_tgt;
      end
    end
  end

  assign o_if_valid      = r_valid;
  assign o_if_kill       = w_kill;
  assign o_pc            = r_pc;
  assign o_snxt_pc       = r_pc + Step;
  assign o_dnxt_pc       = w_pc_nxt;
  assign o_misalign      = r_misalign;
  assign o_misalign_addr = r_misalign_addr;

endmodule
